// File: rtl/pattern_tx_pkg.sv
// Shared constants for pattern_tx: state encoding and parameter defaults.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pattern_tx_pkg;

    localparam int DW_DEF = 8;
    localparam int CW_DEF = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/bit_timer.sv
// Bit-period down-counter: loads a period, ticks for one cycle when it expires.
// Latency: tick is combinational from the count; a reload lands on the next edge.
// Backpressure: none; the owner reloads on every tick while it keeps the timer enabled.
module bit_timer
    import pattern_tx_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_load,
    input  logic [CW-1:0] i_div,
    output logic          o_tick
);

    logic [CW-1:0] r_cnt;

    // Count down from the loaded period and park at zero until reloaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_div;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: sends pattern[len:0] MSB-first, repeated reps+1 times with gaps.
// Latency: first bit appears on w in the cycle right after the edge that accepts start.
// Backpressure: none; start is only looked at in IDLE, all other times it is ignored.
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] pattern,
    input  logic [2:0]    len,
    input  logic [CW-1:0] div,
    input  logic [CW-1:0] reps,
    output logic          w,
    output logic          w_valid,
    output logic          busy,
    output logic          done,
    output logic [7:0]    hits
);

    logic [1:0]    r_state;
    logic [DW-1:0] r_pat;
    logic [2:0]    r_len;
    logic [CW-1:0] r_div;
    logic [CW-1:0] r_reps;
    logic [CW-1:0] r_rep_cnt;
    logic [2:0]    r_idx;
    logic          r_w;
    logic          r_w_valid;
    logic          r_busy;
    logic          r_done;
    logic [7:0]    r_hits;

    logic          w_accept;
    logic          w_tick;
    logic          w_load;
    logic          w_tmr_en;
    logic [CW-1:0] w_div_load;
    logic [2:0]    w_next_idx;
    logic          w_next_bit;

    // The timer is reloaded at every bit/gap boundary; on accept the shadow div is not yet valid.
    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_tmr_en   = (r_state == ST_SHIFT) || (r_state == ST_GAP);
    assign w_load     = w_accept || w_tick;
    assign w_div_load = w_accept ? div : r_div;
    assign w_next_idx = r_idx - 3'd1;
    assign w_next_bit = r_pat[w_next_idx];

    bit_timer #(
        .CW(CW)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_tmr_en),
        .i_load (w_load),
        .i_div  (w_div_load),
        .o_tick (w_tick)
    );

    // Main sequencer. r_w doubles as the previous-bit history for hits, so
    // forcing it to 0 in GAP keeps pairs from spanning two repetitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pat     <= '0;
            r_len     <= '0;
            r_div     <= '0;
            r_reps    <= '0;
            r_rep_cnt <= '0;
            r_idx     <= '0;
            r_w       <= 1'b0;
            r_w_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hits    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_pat     <= pattern;
                        r_len     <= len;
                        r_div     <= div;
                        r_reps    <= reps;
                        r_rep_cnt <= '0;
                        r_idx     <= len;
                        r_w       <= pattern[len];
                        r_w_valid <= 1'b1;
                        r_busy    <= 1'b1;
                        r_hits    <= '0;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_tick) begin
                        if (r_idx != 3'd0) begin
                            r_idx <= w_next_idx;
                            r_w   <= w_next_bit;
                            if (w_next_bit && r_w && (r_hits != 8'hFF)) begin
                                r_hits <= r_hits + 8'd1;
                            end
                        end else if (r_rep_cnt != r_reps) begin
                            r_w       <= 1'b0;
                            r_w_valid <= 1'b0;
                            r_state   <= ST_GAP;
                        end else begin
                            r_w       <= 1'b0;
                            r_w_valid <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= ST_DONE;
                        end
                    end
                end
                ST_GAP: begin
                    if (w_tick) begin
                        r_rep_cnt <= r_rep_cnt + 1'b1;
                        r_idx     <= r_len;
                        r_w       <= r_pat[r_len];
                        r_w_valid <= 1'b1;
                        r_state   <= ST_SHIFT;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w       = r_w;
    assign w_valid = r_w_valid;
    assign busy    = r_busy;
    assign done    = r_done;
    assign hits    = r_hits;

endmodule

// File: tb/tb_pattern_tx.sv
// Directed bench for pattern_tx with a per-cycle expected-trace scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_pattern_tx;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] pattern;
    logic [2:0] len;
    logic [3:0] div;
    logic [3:0] reps;
    logic       w;
    logic       w_valid;
    logic       busy;
    logic       done;
    logic [7:0] hits;

    logic       s_start;
    logic [7:0] s_pattern;
    logic [2:0] s_len;
    logic [5:0] s_div;
    logic [5:0] s_reps;
    logic       s_w;
    logic       s_w_valid;
    logic       s_busy;
    logic       s_done;
    logic [7:0] s_hits;

    int n_cmp;
    int n_err;

    // expected {busy, w_valid, w, done} per cycle
    logic [3:0] exp_q[$];

    pattern_tx u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pattern (pattern),
        .len     (len),
        .div     (div),
        .reps    (reps),
        .w       (w),
        .w_valid (w_valid),
        .busy    (busy),
        .done    (done),
        .hits    (hits)
    );

    // wider repeat field so that the hits counter can be driven into saturation
    pattern_tx #(.DW(8), .CW(6)) u_sat (
        .clk     (clk),
        .rst     (rst),
        .start   (s_start),
        .pattern (s_pattern),
        .len     (s_len),
        .div     (s_div),
        .reps    (s_reps),
        .w       (s_w),
        .w_valid (s_w_valid),
        .busy    (s_busy),
        .done    (s_done),
        .hits    (s_hits)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // two-consecutive-ones Moore detector fed by w
    logic [1:0] det_st;
    logic       det_z;
    logic       det_z_q;
    logic       det_clr;
    int         z_rises;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            det_st <= 2'd0;
        end else begin
            case (det_st)
                2'd0:    det_st <= w ? 2'd1 : 2'd0;
                2'd1:    det_st <= w ? 2'd2 : 2'd0;
                default: det_st <= w ? 2'd2 : 2'd0;
            endcase
        end
    end

    assign det_z = (det_st == 2'd2);

    always_ff @(posedge clk) begin
        det_z_q <= det_z;
        if (det_clr) begin
            z_rises <= 0;
        end else if (det_z && !det_z_q) begin
            z_rises <= z_rises + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Build the expected trace, pulse start, then compare every cycle until back in IDLE.
    // perturb_at >= 0 re-pulses start with different inputs on that trace cycle.
    task automatic run_tx(input logic [7:0] p, input logic [2:0] l, input logic [3:0] d,
                          input logic [3:0] r, input int perturb_at, output logic [7:0] eh);
        int n_busy;
        int n_done;
        int exp_busy;
        int cyc;
        logic [3:0] e;
        exp_q.delete();
        eh = 8'd0;
        for (int k = 0; k <= int'(r); k++) begin
            for (int b = int'(l); b >= 0; b--) begin
                for (int c = 0; c <= int'(d); c++) exp_q.push_back({1'b1, 1'b1, p[b], 1'b0});
                if (b < int'(l) && p[b] && p[b+1] && eh != 8'hFF) eh++;
            end
            if (k < int'(r)) begin
                for (int c = 0; c <= int'(d); c++) exp_q.push_back(4'b1000);
            end
        end
        exp_q.push_back(4'b1001);
        exp_q.push_back(4'b0000);
        exp_busy = (int'(r) + 1) * (int'(l) + 1) * (int'(d) + 1) + int'(r) * (int'(d) + 1) + 1;

        pattern = p;
        len     = l;
        div     = d;
        reps    = r;
        start   = 1'b1;
        @(negedge clk);
        cyc    = 0;
        n_busy = 0;
        n_done = 0;
        while (exp_q.size() > 0) begin
            start = (cyc == perturb_at);
            if (cyc == perturb_at) begin
                pattern = 8'h00;
                len     = 3'd1;
                div     = 4'd5;
                reps    = 4'd3;
            end
            e = exp_q.pop_front();
            check("trace", {28'd0, busy, w_valid, w, done}, {28'd0, e});
            if (busy) n_busy++;
            if (done) n_done++;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_cycles", n_busy, exp_busy);
        check("done_pulses", n_done, 1);
        check("hits_model", {24'd0, hits}, {24'd0, eh});
    endtask

    initial begin
        logic [7:0] eh;
        logic       seen;
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        start     = 1'b0;
        pattern   = 8'h00;
        len       = 3'd0;
        div       = 4'd0;
        reps      = 4'd0;
        s_start   = 1'b0;
        s_pattern = 8'h00;
        s_len     = 3'd0;
        s_div     = 6'd0;
        s_reps    = 6'd0;
        det_clr   = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_outs", {28'd0, busy, w_valid, w, done}, 32'd0);
        check("rst_hits", {24'd0, hits}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // scenario 1: full byte, one bit per clock
        run_tx(8'b10110110, 3'd7, 4'd0, 4'd0, -1, eh);
        check("s1_hits", {24'd0, hits}, 32'd2);
        pattern = 8'h55;
        repeat (3) @(negedge clk);
        check("hits_hold_idle", {24'd0, hits}, 32'd2);

        // scenario 2: stretched bits with one repeat
        run_tx(8'hFF, 3'd2, 4'd2, 4'd1, -1, eh);
        check("s2_hits", {24'd0, hits}, 32'd4);

        // scenario 3: start re-pulsed and inputs changed mid-SHIFT
        run_tx(8'b10110110, 3'd7, 4'd0, 4'd0, 3, eh);
        check("s3_hits", {24'd0, hits}, 32'd2);

        // scenario 4: asynchronous reset mid-SHIFT
        pattern = 8'hFF;
        len     = 3'd7;
        div     = 4'd3;
        reps    = 4'd0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_outs", {28'd0, busy, w_valid, w, done}, 32'd0);
        check("async_rst_hits", {24'd0, hits}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_tx(8'h03, 3'd1, 4'd0, 4'd0, -1, eh);
        check("s4_hits", {24'd0, hits}, 32'd1);

        // scenario 5: single-bit pattern, longest period and repeat count
        run_tx(8'h01, 3'd0, 4'd15, 4'd15, -1, eh);
        check("s5_hits", {24'd0, hits}, 32'd0);

        // scenario 6: loop w into the detector
        det_clr = 1'b1;
        @(negedge clk);
        det_clr = 1'b0;
        run_tx(8'b11011011, 3'd7, 4'd0, 4'd1, -1, eh);
        repeat (2) @(negedge clk);
        check("det_vs_hits", z_rises, {24'd0, hits});
        check("s6_hits", {24'd0, hits}, 32'd6);

        // hits saturation: 41 repetitions of 7 pairs each
        s_pattern = 8'hFF;
        s_len     = 3'd7;
        s_div     = 6'd0;
        s_reps    = 6'd40;
        s_start   = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        seen    = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            if (s_done) seen = 1'b1;
            else @(negedge clk);
        end
        check("sat_done_seen", {31'd0, seen}, 32'd1);
        @(negedge clk);
        check("sat_hits", {24'd0, s_hits}, 32'd255);
        check("sat_idle", {31'd0, s_busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
